dht_multi_reader: RTL and testbench
===================================

// Module: dht_multi_reader
// PURPOSE
//  Round-robin acquisition engine for N_CH single-wire DHT11/DHT22 humidity/temperature sensors.
//  It drives each open-drain DATA line through the start pulse, then decodes the 40-bit frame
//  and verifies the checksum. Each result (or error) is presented on a valid/ready output port
//  that feeds the UART reporting path. A programmable wait separates successive acquisitions.
// PARAMETERS
//  CLK_HZ      25000000  CLK frequency in Hz; all timings are derived from it
//  N_CH        2         sensor channel count (1..8)
//  PERIOD_MS   2000      wait after each frame before the next channel starts
//  START_US    18000     host low-pulse length (DHT11)
//  BIT_THR_US  50        high-phase length at or above which a bit decodes as '1'
//  TIMEOUT_US  200       maximum duration of any sensor-driven phase
// PORTS
//  CLK        in   1          system clock
//  RESET      in   1          asynchronous, active-high
//  ENABLE     in   1          run acquisitions while high
//  DATA_IN    in   N_CH       raw line levels from the pads (asynchronous)
//  DATA_OE    out  N_CH       1 = pull line low; 0 = release (pad pull-up)
//  OUT_VALID  out  1          result available
//  OUT_READY  in   1          consumer accepts the result
//  OUT_CH     out  3          channel number of the result
//  OUT_RH     out  16         humidity, {int,dec}
//  OUT_T      out  16         temperature, {int,dec}
//  OUT_ERR    out  2          00 ok, 01 checksum fail, 10 timeout
//  BUSY       out  1          high when FSM is not IDLE
// BEHAVIOUR
//  - Reset: DATA_OE=0, OUT_VALID=0, OUT_CH/RH/T/ERR=0, BUSY=0, channel pointer=0, FSM=IDLE.
//  - DATA_IN passes through a 2-FF synchronizer per channel; all edges are detected on the
//    synchronized bit, giving 2-cycle input latency.
//  - All timing uses a single 32-bit cycle counter, cleared on every state change.
//  - FSM (current channel c):
//    IDLE    : leave when ENABLE=1 and OUT_VALID=0 -> START.
//    START   : DATA_OE[c]=1 for START cycles -> REL.
//    REL     : OE released; wait for line low -> RSP_L.
//    RSP_L   : wait for line high -> RSP_H.
//    RSP_H   : wait for line low -> BIT_L (bit index 39).
//    BIT_L   : wait for line high -> BIT_H.
//    BIT_H   : count high cycles until line low. Bit = (count >= BIT_THR); stored MSB first.
//              After bit 0 -> CHECK, otherwise -> BIT_L.
//    CHECK   : 1 cycle. Compare byte0+byte1+byte2+byte3 (mod 256) against byte4. Load outputs
//              and set OUT_VALID=1 -> HOLD.
//    HOLD    : when OUT_VALID && OUT_READY, clear OUT_VALID next cycle -> WAIT.
//    WAIT    : PERIOD cycles; then c = (c==N_CH-1) ? 0 : c+1 -> IDLE.
//  - Timeout: any of REL..BIT_H lasting TIMEOUT cycles -> CHECK path with OUT_ERR=10 and RH/T=0.
//    OUT_VALID is still raised; the channel is skipped for this round only.
//  - A checksum fail reports OUT_ERR=01 with RH/T carrying the raw received bytes.
//  - OUT_* are stable while OUT_VALID=1 and OUT_READY=0; there is no overwrite and no drop.
//  - ENABLE is sampled only in IDLE. Dropping it mid-frame finishes the frame and its handshake.
//  - RESET mid-frame releases DATA_OE within the same cycle (asynchronous clear).
//  - Only channel c is ever driven; at most one DATA_OE bit is high at any time.
// CONFIGURATION
//  DHT22_MODE_EN defined: START is fixed at 1 ms.
//    OUT_RH  = {byte0,byte1}, unsigned humidity x10.
//    OUT_T   = {byte2,byte3}; bit15 = sign, [14:0] = magnitude x10.
//  Not defined: DHT11 format.
//    OUT_RH  = {byte0,byte1}, OUT_T = {byte2,byte3}, START = START_US.
//  The checksum rule is identical in both modes.
// TESTING  (sim scaling: CLK_HZ=1000000, PERIOD_MS=1, N_CH=2)
//  1. Sensor model ch0 sends 0x28,0x00,0x19,0x00,0x41 -> OUT_VALID with OUT_CH=0,
//     OUT_RH=0x2800, OUT_T=0x1900, OUT_ERR=00. START pulse measured as 18000 cycles.
//  2. ch1 sends checksum byte 0x40 instead of 0x41 -> OUT_ERR=01, OUT_CH=1, raw bytes present.
//  3. ch0 silent (line stays high after REL) -> OUT_ERR=10 after 200 cycles, then ch1 proceeds.
//  4. Hold OUT_READY=0 for 5000 cycles -> outputs stable and no new START; after READY=1,
//     OUT_VALID drops one cycle later.
//  5. Assert RESET during BIT_H of bit 20 -> DATA_OE=0, OUT_VALID=0; restart begins at ch0.
//  6. DHT22_MODE_EN: frame 0x02,0x8C,0x80,0x65,0x73 -> OUT_RH=0x028C, OUT_T=0x8065
//     (-10.1 C), START = 1000 cycles.

Source files
------------

// File: rtl/dht_multi_reader.sv
// ---------------------------------------------------------------------------
// dht_multi_reader
//
// Round-robin acquisition engine for N_CH single-wire DHT11/DHT22 sensors.
// For the current channel it drives the open-drain start pulse, follows the
// sensor's response preamble and decodes the 40-bit frame MSB first. It then
// checks the checksum and presents the result on a valid/ready port. After
// the result is accepted, a programmable wait passes before the next channel
// is started.
//
// Build option:
//   DHT22_MODE_EN  defined   : start pulse fixed at 1 ms (DHT22 timing);
//                              OUT_T bit15 is the sign, [14:0] magnitude x10.
//                  undefined : start pulse is START_US (DHT11 timing).
//   The byte placement and the checksum rule are identical in both modes.
//
// Ports:
//   CLK        in   1      system clock
//   RESET      in   1      asynchronous, active-high
//   ENABLE     in   1      run acquisitions while high (sampled in IDLE only)
//   DATA_IN    in   N_CH   raw pad levels (asynchronous, 2-FF synchronized)
//   DATA_OE    out  N_CH   1 = pull line low, 0 = release to pull-up
//   OUT_VALID  out  1      result available
//   OUT_READY  in   1      consumer accepts the result
//   OUT_CH     out  3      channel of the result
//   OUT_RH     out  16     {byte0,byte1}
//   OUT_T      out  16     {byte2,byte3}
//   OUT_ERR    out  2      00 ok, 01 checksum fail, 10 timeout
//   BUSY       out  1      FSM not in IDLE
// ---------------------------------------------------------------------------
module dht_multi_reader #(
  parameter int unsigned CLK_HZ     = 25000000,
  parameter int unsigned N_CH       = 2,
  parameter int unsigned PERIOD_MS  = 2000,
  parameter int unsigned START_US   = 18000,
  parameter int unsigned BIT_THR_US = 50,
  parameter int unsigned TIMEOUT_US = 200
) (
  input  logic            CLK,
  input  logic            RESET,
  input  logic            ENABLE,
  input  logic [N_CH-1:0] DATA_IN,
  output logic [N_CH-1:0] DATA_OE,
  output logic            OUT_VALID,
  input  logic            OUT_READY,
  output logic [2:0]      OUT_CH,
  output logic [15:0]     OUT_RH,
  output logic [15:0]     OUT_T,
  output logic [1:0]      OUT_ERR,
  output logic            BUSY
);

  localparam int unsigned CW = (N_CH > 1) ? $clog2(N_CH) : 1;

  // Cycle count for a duration, computed in 64 bits so large CLK_HZ values
  // do not overflow; never returns 0 so every "count-1" compare is valid.
  function automatic logic [31:0] cycles_of(input longint unsigned num,
                                            input longint unsigned den);
    longint unsigned v;
    v = num / den;
    if (v == 0) v = 1;
    return v[31:0];
  endfunction

`ifdef DHT22_MODE_EN
  localparam logic [31:0] START_CYC = cycles_of(64'(CLK_HZ), 64'd1000);
`else
  localparam logic [31:0] START_CYC = cycles_of(64'(CLK_HZ) * START_US, 64'd1000000);
`endif
  localparam logic [31:0] PERIOD_CYC  = cycles_of(64'(CLK_HZ) * PERIOD_MS,  64'd1000);
  localparam logic [31:0] BIT_THR_CYC = cycles_of(64'(CLK_HZ) * BIT_THR_US, 64'd1000000);
  localparam logic [31:0] TIMEOUT_CYC = cycles_of(64'(CLK_HZ) * TIMEOUT_US, 64'd1000000);

  typedef enum logic [3:0] {
    S_IDLE,
    S_START,
    S_REL,
    S_RSP_L,
    S_RSP_H,
    S_BIT_L,
    S_BIT_H,
    S_CHECK,
    S_HOLD,
    S_WAIT
  } state_t;

  // -------------------------------------------------------------------------
  // Input synchronizers. Lines idle high (pull-up), so the flops reset to 1
  // to avoid a spurious falling edge right after reset.
  // -------------------------------------------------------------------------
  logic [N_CH-1:0] meta_q;
  logic [N_CH-1:0] sync_q;
  logic [N_CH-1:0] prev_q;

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      meta_q <= '1;
      sync_q <= '1;
      prev_q <= '1;
    end else begin
      meta_q <= DATA_IN;
      sync_q <= meta_q;
      prev_q <= sync_q;
    end
  end

  // -------------------------------------------------------------------------
  // State
  // -------------------------------------------------------------------------
  state_t          state_q, state_d;
  logic [31:0]     cnt_q, cnt_d;
  logic [CW-1:0]   ch_q, ch_d;
  logic [5:0]      bit_idx_q, bit_idx_d;
  logic [39:0]     shift_q, shift_d;
  logic            tmo_q, tmo_d;
  logic [N_CH-1:0] oe_q, oe_d;
  logic            valid_q, valid_d;
  logic [2:0]      out_ch_q, out_ch_d;
  logic [15:0]     out_rh_q, out_rh_d;
  logic [15:0]     out_t_q, out_t_d;
  logic [1:0]      out_err_q, out_err_d;

  // Edges of the selected channel, taken on the synchronized bit. Using
  // edges (not levels) matters in REL: the synchronizer still shows the
  // host-driven low for two cycles after the line is released.
  logic line_rise, line_fall;
  assign line_rise =  sync_q[ch_q] & ~prev_q[ch_q];
  assign line_fall = ~sync_q[ch_q] &  prev_q[ch_q];

  logic timed_out;
  assign timed_out = (cnt_q >= TIMEOUT_CYC - 32'd1);

  logic [7:0] sum8;
  assign sum8 = shift_q[39:32] + shift_q[31:24] + shift_q[23:16] + shift_q[15:8];

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q + 32'd1;
    ch_d      = ch_q;
    bit_idx_d = bit_idx_q;
    shift_d   = shift_q;
    tmo_d     = tmo_q;
    valid_d   = valid_q;
    out_ch_d  = out_ch_q;
    out_rh_d  = out_rh_q;
    out_t_d   = out_t_q;
    out_err_d = out_err_q;
    oe_d      = '0;

    case (state_q)
      S_IDLE: begin
        if (ENABLE && !valid_q) state_d = S_START;
      end

      S_START: begin
        if (cnt_q == START_CYC - 32'd1) state_d = S_REL;
      end

      S_REL: begin
        if (line_fall)      state_d = S_RSP_L;
        else if (timed_out) begin
          state_d = S_CHECK;
          tmo_d   = 1'b1;
        end
      end

      S_RSP_L: begin
        if (line_rise)      state_d = S_RSP_H;
        else if (timed_out) begin
          state_d = S_CHECK;
          tmo_d   = 1'b1;
        end
      end

      S_RSP_H: begin
        if (line_fall) begin
          state_d   = S_BIT_L;
          bit_idx_d = 6'd39;
        end else if (timed_out) begin
          state_d = S_CHECK;
          tmo_d   = 1'b1;
        end
      end

      S_BIT_L: begin
        if (line_rise)      state_d = S_BIT_H;
        else if (timed_out) begin
          state_d = S_CHECK;
          tmo_d   = 1'b1;
        end
      end

      S_BIT_H: begin
        // cnt_q holds the high cycles seen so far in this bit.
        if (line_fall) begin
          shift_d = {shift_q[38:0], (cnt_q >= BIT_THR_CYC)};
          if (bit_idx_q == 6'd0) begin
            state_d = S_CHECK;
          end else begin
            bit_idx_d = bit_idx_q - 6'd1;
            state_d   = S_BIT_L;
          end
        end else if (timed_out) begin
          state_d = S_CHECK;
          tmo_d   = 1'b1;
        end
      end

      S_CHECK: begin
        out_ch_d = 3'(ch_q);
        if (tmo_q) begin
          out_err_d = 2'b10;
          out_rh_d  = 16'h0000;
          out_t_d   = 16'h0000;
        end else begin
          out_err_d = (sum8 == shift_q[7:0]) ? 2'b00 : 2'b01;
          out_rh_d  = shift_q[39:24];
          out_t_d   = shift_q[23:8];
        end
        valid_d = 1'b1;
        tmo_d   = 1'b0;
        state_d = S_HOLD;
      end

      S_HOLD: begin
        if (valid_q && OUT_READY) begin
          valid_d = 1'b0;
          state_d = S_WAIT;
        end
      end

      S_WAIT: begin
        if (cnt_q == PERIOD_CYC - 32'd1) begin
          ch_d    = (ch_q == CW'(N_CH - 1)) ? '0 : ch_q + 1'b1;
          state_d = S_IDLE;
        end
      end

      default: state_d = S_IDLE;
    endcase

    if (state_d != state_q) cnt_d = 32'd0;

    // Registered drive: the pad is pulled low exactly for the cycles spent
    // in START, and only on the current channel.
    for (int i = 0; i < N_CH; i++) begin
      oe_d[i] = (state_d == S_START) && (ch_q == CW'(i));
    end
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_q   <= S_IDLE;
      cnt_q     <= 32'd0;
      ch_q      <= '0;
      bit_idx_q <= 6'd0;
      shift_q   <= 40'd0;
      tmo_q     <= 1'b0;
      oe_q      <= '0;
      valid_q   <= 1'b0;
      out_ch_q  <= 3'd0;
      out_rh_q  <= 16'd0;
      out_t_q   <= 16'd0;
      out_err_q <= 2'd0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      ch_q      <= ch_d;
      bit_idx_q <= bit_idx_d;
      shift_q   <= shift_d;
      tmo_q     <= tmo_d;
      oe_q      <= oe_d;
      valid_q   <= valid_d;
      out_ch_q  <= out_ch_d;
      out_rh_q  <= out_rh_d;
      out_t_q   <= out_t_d;
      out_err_q <= out_err_d;
    end
  end

  assign DATA_OE   = oe_q;
  assign OUT_VALID = valid_q;
  assign OUT_CH    = out_ch_q;
  assign OUT_RH    = out_rh_q;
  assign OUT_T     = out_t_q;
  assign OUT_ERR   = out_err_q;
  assign BUSY      = (state_q != S_IDLE);

endmodule

// File: tb/tb_dht_multi_reader.sv
`timescale 1ns/1ps
// Testbench for dht_multi_reader: sensor line model, scoreboard of expected
// results derived from the frame bytes, and a per-cycle compare process.
module tb_dht_multi_reader;

  localparam int unsigned CLK_HZ     = 1000000;
  localparam int unsigned N_CH       = 2;
  localparam int unsigned PERIOD_MS  = 1;
  localparam int unsigned START_US   = 18000;
  localparam int unsigned BIT_THR_US = 50;
  localparam int unsigned TIMEOUT_US = 200;

`ifdef DHT22_MODE_EN
  localparam int START_EXP = CLK_HZ / 1000;
  localparam logic [39:0] FRAME1 = 40'h028C806573;
  localparam logic [15:0] RH1 = 16'h028C;
  localparam logic [15:0] T1  = 16'h8065;
`else
  localparam int START_EXP = int'(64'(CLK_HZ) * START_US / 1000000);
  localparam logic [39:0] FRAME1 = 40'h2800190041;
  localparam logic [15:0] RH1 = 16'h2800;
  localparam logic [15:0] T1  = 16'h1900;
`endif
  localparam int TIMEOUT_EXP = TIMEOUT_US * (CLK_HZ / 1000000);

  logic            CLK;
  logic            RESET;
  logic            ENABLE;
  logic [N_CH-1:0] DATA_IN;
  logic [N_CH-1:0] DATA_OE;
  logic            OUT_VALID;
  logic            OUT_READY;
  logic [2:0]      OUT_CH;
  logic [15:0]     OUT_RH;
  logic [15:0]     OUT_T;
  logic [1:0]      OUT_ERR;
  logic            BUSY;

  logic [N_CH-1:0] sens_low;

  // Open-drain line: low if the host or the sensor pulls it.
  assign DATA_IN = ~(DATA_OE | sens_low);

  dht_multi_reader #(
    .CLK_HZ(CLK_HZ), .N_CH(N_CH), .PERIOD_MS(PERIOD_MS),
    .START_US(START_US), .BIT_THR_US(BIT_THR_US), .TIMEOUT_US(TIMEOUT_US)
  ) dut (
    .CLK(CLK), .RESET(RESET), .ENABLE(ENABLE), .DATA_IN(DATA_IN),
    .DATA_OE(DATA_OE), .OUT_VALID(OUT_VALID), .OUT_READY(OUT_READY),
    .OUT_CH(OUT_CH), .OUT_RH(OUT_RH), .OUT_T(OUT_T), .OUT_ERR(OUT_ERR),
    .BUSY(BUSY)
  );

  initial CLK = 1'b0;
  always #500 CLK = ~CLK;

  typedef struct packed {
    logic [2:0]  ch;
    logic [15:0] rh;
    logic [15:0] t;
    logic [1:0]  err;
  } res_t;

  res_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  int   exp_ch = 0;
  bit   last_hs = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, req, $time);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge CLK);
    #1;
  endtask

  // What the reader must report for a frame, straight from the byte rules.
  function automatic res_t model(input int ch, input bit silent, input logic [39:0] f);
    res_t r;
    logic [7:0] s;
    r.ch = 3'(ch);
    if (silent) begin
      r.rh = 16'h0; r.t = 16'h0; r.err = 2'b10;
    end else begin
      s = f[39:32] + f[31:24] + f[23:16] + f[15:8];
      r.rh  = f[39:24];
      r.t   = f[23:8];
      r.err = (s == f[7:0]) ? 2'b00 : 2'b01;
    end
    return r;
  endfunction

  // Per-cycle compare against the scoreboard front.
  always @(negedge CLK) begin
    bit hs_now;
    if (RESET) begin
      last_hs = 1'b0;
    end else begin
      chk("oe_onehot", 64'($countones(DATA_OE) <= 1), 64'd1);
      chk("valid_drop_after_hs", 64'(OUT_VALID & last_hs), 64'd0);
      if (OUT_VALID || DATA_OE != '0) chk("busy", 64'(BUSY), 64'd1);
      hs_now = 1'b0;
      if (OUT_VALID) begin
        if (exp_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_result: got ch=%0d err=%0b, expected none", OUT_CH, OUT_ERR);
        end else begin
          chk("out_word", 64'({OUT_CH, OUT_RH, OUT_T, OUT_ERR}), 64'(exp_q[0]));
          chk("no_start_while_valid", 64'(DATA_OE), 64'd0);
          if (OUT_READY) begin
            void'(exp_q.pop_front());
            hs_now = 1'b1;
          end
        end
      end
      last_hs = hs_now;
    end
  end

  // One acquisition: detect and measure the start pulse, then play the
  // sensor. abort_bit >= 0 stops in the middle of that bit's high phase.
  task automatic acq(input bit silent, input logic [39:0] frame, input int abort_bit,
                     output bit ok);
    int n, cur, hi;
    logic [N_CH-1:0] oh;
    ok = 1'b0;
    n = 0;
    while (DATA_OE == '0 && n < 3000) begin cyc(1); n++; end
    chk("start_seen", 64'(DATA_OE != '0), 64'd1);
    if (DATA_OE == '0) return;
    oh = '0; oh[exp_ch] = 1'b1;
    chk("start_ch", 64'(DATA_OE), 64'(oh));
    n = 0;
    while (DATA_OE != '0 && n < 40000) begin cyc(1); n++; end
    chk("start_len", 64'(n), 64'(START_EXP));
    cur = exp_ch;
    exp_q.push_back(model(cur, silent, frame));
    exp_ch = (exp_ch + 1) % N_CH;
    $display("acq ch=%0d silent=%0b frame=%010h start=%0d", cur, silent, frame, n);
    if (silent) begin
      n = 0;
      while (!OUT_VALID && n < 400) begin cyc(1); n++; end
      chk("timeout_len", 64'(n >= TIMEOUT_EXP && n <= TIMEOUT_EXP + 4), 64'd1);
      ok = 1'b1;
      return;
    end
    cyc(20 + int'($urandom_range(20)));
    sens_low[cur] = 1'b1; cyc(80);
    sens_low[cur] = 1'b0; cyc(80);
    for (int i = 39; i >= 0; i--) begin
      sens_low[cur] = 1'b1; cyc(50 + int'($urandom_range(4)));
      sens_low[cur] = 1'b0;
      hi = frame[i] ? 68 + int'($urandom_range(4)) : 24 + int'($urandom_range(4));
      if (i == abort_bit) begin
        cyc(hi / 2);
        return;
      end
      cyc(hi);
    end
    sens_low[cur] = 1'b1; cyc(50);
    sens_low[cur] = 1'b0;
    n = 0;
    while (!OUT_VALID && n < 100) begin cyc(1); n++; end
    chk("valid_after_frame", 64'(OUT_VALID), 64'd1);
    ok = 1'b1;
  endtask

  task automatic handshake(input int hold);
    OUT_READY = 1'b0;
    cyc(hold);
    OUT_READY = 1'b1;
    cyc(1);
    OUT_READY = 1'b0;
    chk("valid_drop", 64'(OUT_VALID), 64'd0);
    $display("handshake after %0d hold cycles", hold);
  endtask

  initial begin
    bit ok;
    logic [39:0] rf;
    logic [7:0]  b0, b1, b2, b3;
    RESET = 1'b1; ENABLE = 1'b0; OUT_READY = 1'b0; sens_low = '0;
    cyc(3);
    chk("rst_oe", 64'(DATA_OE), 64'd0);
    chk("rst_valid", 64'(OUT_VALID), 64'd0);
    chk("rst_word", 64'({OUT_CH, OUT_RH, OUT_T, OUT_ERR}), 64'd0);
    chk("rst_busy", 64'(BUSY), 64'd0);
    RESET = 1'b0;
    cyc(20);
    chk("idle_disabled_busy", 64'(BUSY), 64'd0);
    chk("idle_disabled_oe", 64'(DATA_OE), 64'd0);
    ENABLE = 1'b1;

    // ch0 good frame
    acq(1'b0, FRAME1, -1, ok);
    chk("t1_ch", 64'(OUT_CH), 64'd0);
    chk("t1_rh", 64'(OUT_RH), 64'(RH1));
    chk("t1_t", 64'(OUT_T), 64'(T1));
    chk("t1_err", 64'(OUT_ERR), 64'd0);
    handshake(1 + int'($urandom_range(20)));

    // ch1 bad checksum, raw bytes still reported
    acq(1'b0, 40'h2800190040, -1, ok);
    chk("t2_ch", 64'(OUT_CH), 64'd1);
    chk("t2_err", 64'(OUT_ERR), 64'd1);
    chk("t2_raw", 64'({OUT_RH, OUT_T}), 64'h28001900);
    handshake(1 + int'($urandom_range(20)));

    // ch0 silent -> timeout; consumer stalls 5000 cycles
    acq(1'b1, 40'h0, -1, ok);
    chk("t3_ch", 64'(OUT_CH), 64'd0);
    chk("t3_err", 64'(OUT_ERR), 64'd2);
    chk("t3_data", 64'({OUT_RH, OUT_T}), 64'd0);
    handshake(5000);
    chk("t4_no_start_after_stall", 64'(DATA_OE), 64'd0);

    // ch1 random valid frame, reset in the high phase of bit 20
    b0 = 8'($urandom); b1 = 8'($urandom); b2 = 8'($urandom); b3 = 8'($urandom);
    rf = {b0, b1, b2, b3, 8'(b0 + b1 + b2 + b3)};
    acq(1'b0, rf, 20, ok);
    chk("t5_busy_before_reset", 64'(BUSY), 64'd1);
    #100 RESET = 1'b1;
    #1;
    chk("t5_rst_oe", 64'(DATA_OE), 64'd0);
    chk("t5_rst_valid", 64'(OUT_VALID), 64'd0);
    chk("t5_rst_busy", 64'(BUSY), 64'd0);
    exp_q.delete();
    sens_low = '0;
    exp_ch = 0;
    cyc(3);
    RESET = 1'b0;
    $display("reset during frame, restart expected on ch0");

    // restart must begin at ch0; then reset during START drops OE at once
    begin
      int n;
      n = 0;
      while (DATA_OE == '0 && n < 100) begin cyc(1); n++; end
      chk("t5_restart_ch0", 64'(DATA_OE), 64'd1);
    end
    cyc(10);
    #100 RESET = 1'b1;
    #1;
    chk("t5_async_oe_release", 64'(DATA_OE), 64'd0);
    cyc(2);
    RESET = 1'b0;
    cyc(2);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
